// File: rtl/reg_file_alu_pkg.sv
// Shared definitions for the register-file/ALU datapath core:
// ALU function encodings and the default datapath dimensions.
package reg_file_alu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 4;

    typedef enum logic [2:0] {
        FN_ADD  = 3'd0,
        FN_ADDC = 3'd1,
        FN_SUB  = 3'd2,
        FN_SUBB = 3'd3,
        FN_AND  = 3'd4,
        FN_XOR  = 3'd5,
        FN_NOT  = 3'd6,
        FN_PASS = 3'd7
    } alu_func_e;

endpackage

// File: rtl/reg_file_with_alu_alu.sv
// Purely combinational ALU: arithmetic with carry/borrow out, logic ops and pass-through.
// Borrow is bit DATA_W of the (DATA_W+1)-bit difference, set whenever A < B (+ borrow-in).
module alu
    import reg_file_alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        func,
    input  logic              crIn,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic [DATA_W:0] wide_s;

    // Operation decode; every encoding of func is a defined operation.
    always_comb begin
        wide_s = '0;
        result = '0;
        carry  = 1'b0;
        case (alu_func_e'(func))
            FN_ADD: begin
                wide_s = {1'b0, a} + {1'b0, b};
                result = wide_s[DATA_W-1:0];
                carry  = wide_s[DATA_W];
            end
            FN_ADDC: begin
                wide_s = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, crIn};
                result = wide_s[DATA_W-1:0];
                carry  = wide_s[DATA_W];
            end
            FN_SUB: begin
                wide_s = {1'b0, a} - {1'b0, b};
                result = wide_s[DATA_W-1:0];
                carry  = wide_s[DATA_W];
            end
            FN_SUBB: begin
                wide_s = {1'b0, a} - {1'b0, b} - {{DATA_W{1'b0}}, crIn};
                result = wide_s[DATA_W-1:0];
                carry  = wide_s[DATA_W];
            end
            FN_AND:  result = a & b;
            FN_XOR:  result = a ^ b;
            FN_NOT:  result = ~a;
            FN_PASS: result = a;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/reg_file_with_alu.sv
// 16 x 32-bit register file feeding a combinational ALU; each edge may write
// external data or the ALU result, and the ALU carry is kept in crOut.
module reg_file_with_alu
    import reg_file_alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] dataIn,
    input  logic [2:0]        func,
    input  logic              crIn,
    input  logic [ADDR_W-1:0] leftAddr,
    input  logic [ADDR_W-1:0] rightAddr,
    input  logic [ADDR_W-1:0] destAddr,
    input  logic              writeEn,
    input  logic              selInput,
    output logic [DATA_W-1:0] dataOut,
    output logic              crOut
);

    localparam int NUM_REGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              cr_q;
    logic              cr_d;
    logic [DATA_W-1:0] alu_result_s;
    logic              alu_carry_s;
    logic [DATA_W-1:0] wdata_s;

    alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a      (regs_q[leftAddr]),
        .b      (regs_q[rightAddr]),
        .func   (func),
        .crIn   (crIn),
        .result (alu_result_s),
        .carry  (alu_carry_s)
    );

    // Write-source mux and next-state for the register array and carry flag.
    always_comb begin
        regs_d  = regs_q;
        cr_d    = cr_q;
        wdata_s = selInput ? alu_result_s : dataIn;
        if (writeEn) begin
            regs_d[destAddr] = wdata_s;
            if (selInput) begin
                cr_d = alu_carry_s;
            end else begin
                cr_d = cr_q;
            end
        end else begin
            regs_d = regs_q;
        end
    end

    // State registers; reset clears every register and the carry flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            cr_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            cr_q   <= cr_d;
        end
    end

    // No bypass: a write becomes visible only after its edge.
    assign dataOut = regs_q[leftAddr];
    assign crOut   = cr_q;

endmodule

// File: tb/tb_reg_file_with_alu.sv
// Self-checking bench for reg_file_with_alu: a directed vector table plus
// hand-written sequences for bypass, asynchronous reset and idle edges.
module tb_reg_file_with_alu;

    logic        clock;
    logic        reset;
    logic [31:0] dataIn;
    logic [2:0]  func;
    logic        crIn;
    logic [3:0]  leftAddr;
    logic [3:0]  rightAddr;
    logic [3:0]  destAddr;
    logic        writeEn;
    logic        selInput;
    logic [31:0] dataOut;
    logic        crOut;

    int n_compared;
    int n_failed;

    typedef struct {
        logic        we;
        logic        sel;
        logic [2:0]  fn;
        logic        ci;
        logic [3:0]  l;
        logic [3:0]  r;
        logic [3:0]  d;
        logic [31:0] din;
        logic [3:0]  chk;
        logic [31:0] exp_d;
        logic        exp_c;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    reg_file_with_alu dut (
        .clock     (clock),
        .reset     (reset),
        .dataIn    (dataIn),
        .func      (func),
        .crIn      (crIn),
        .leftAddr  (leftAddr),
        .rightAddr (rightAddr),
        .destAddr  (destAddr),
        .writeEn   (writeEn),
        .selInput  (selInput),
        .dataOut   (dataOut),
        .crOut     (crOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_compared++;
        if (act !== exp) begin
            n_failed++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic read_reg(input logic [3:0] addr, input logic [31:0] exp, input string name);
        leftAddr = addr;
        #1;
        check32(name, dataOut, exp);
    endtask

    initial begin
        n_compared = 0;
        n_failed   = 0;
        //            we    sel   fn    ci    l      r      d      din           chk    exp_d         exp_c
        vecs[0]  = '{1'b1, 1'b0, 3'd0, 1'b0, 4'd0,  4'd0,  4'd4,  32'd17,       4'd4,  32'd17,       1'b0};
        vecs[1]  = '{1'b1, 1'b0, 3'd0, 1'b0, 4'd0,  4'd0,  4'd6,  32'd2,        4'd6,  32'd2,        1'b0};
        vecs[2]  = '{1'b1, 1'b1, 3'd0, 1'b0, 4'd4,  4'd6,  4'd1,  32'd0,        4'd1,  32'd19,       1'b0};
        vecs[3]  = '{1'b0, 1'b1, 3'd0, 1'b0, 4'd1,  4'd1,  4'd1,  32'd0,        4'd1,  32'd19,       1'b0};
        vecs[4]  = '{1'b0, 1'b0, 3'd3, 1'b1, 4'd1,  4'd1,  4'd1,  32'hDEADBEEF, 4'd1,  32'd19,       1'b0};
        vecs[5]  = '{1'b1, 1'b1, 3'd6, 1'b0, 4'd1,  4'd0,  4'd8,  32'd0,        4'd8,  32'hFFFFFFEC, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 3'd5, 1'b0, 4'd4,  4'd4,  4'd2,  32'd0,        4'd2,  32'd0,        1'b0};
        vecs[7]  = '{1'b1, 1'b1, 3'd2, 1'b0, 4'd4,  4'd2,  4'd4,  32'd0,        4'd4,  32'd17,       1'b0};
        vecs[8]  = '{1'b1, 1'b0, 3'd0, 1'b0, 4'd0,  4'd0,  4'd10, 32'hFFFFFFFF, 4'd10, 32'hFFFFFFFF, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 3'd0, 1'b0, 4'd0,  4'd0,  4'd11, 32'd1,        4'd11, 32'd1,        1'b0};
        vecs[10] = '{1'b1, 1'b1, 3'd0, 1'b0, 4'd10, 4'd11, 4'd12, 32'd0,        4'd12, 32'd0,        1'b1};
        vecs[11] = '{1'b1, 1'b0, 3'd0, 1'b0, 4'd0,  4'd0,  4'd13, 32'd0,        4'd13, 32'd0,        1'b1};
        vecs[12] = '{1'b1, 1'b1, 3'd2, 1'b0, 4'd13, 4'd11, 4'd14, 32'd0,        4'd14, 32'hFFFFFFFF, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 3'd0, 1'b0, 4'd0,  4'd0,  4'd15, 32'd5,        4'd15, 32'd5,        1'b1};
        vecs[14] = '{1'b1, 1'b1, 3'd1, 1'b1, 4'd15, 4'd15, 4'd3,  32'd0,        4'd3,  32'd11,       1'b0};
        vecs[15] = '{1'b1, 1'b1, 3'd3, 1'b1, 4'd4,  4'd15, 4'd5,  32'd0,        4'd5,  32'd11,       1'b0};
        vecs[16] = '{1'b1, 1'b1, 3'd3, 1'b1, 4'd11, 4'd11, 4'd7,  32'd0,        4'd7,  32'hFFFFFFFF, 1'b1};
        vecs[17] = '{1'b1, 1'b1, 3'd4, 1'b0, 4'd10, 4'd4,  4'd9,  32'd0,        4'd9,  32'd17,       1'b0};
        vecs[18] = '{1'b1, 1'b1, 3'd7, 1'b0, 4'd4,  4'd0,  4'd0,  32'd0,        4'd0,  32'd17,       1'b0};
        vecs[19] = '{1'b1, 1'b1, 3'd1, 1'b1, 4'd10, 4'd13, 4'd6,  32'd0,        4'd6,  32'd0,        1'b1};
        vecs[20] = '{1'b1, 1'b1, 3'd0, 1'b1, 4'd15, 4'd15, 4'd6,  32'd0,        4'd6,  32'd10,       1'b0};
        vecs[21] = '{1'b1, 1'b1, 3'd0, 1'b0, 4'd15, 4'd15, 4'd15, 32'd0,        4'd15, 32'd10,       1'b0};
        vecs[22] = '{1'b0, 1'b0, 3'd0, 1'b0, 4'd0,  4'd0,  4'd15, 32'd99,       4'd15, 32'd10,       1'b0};

        reset = 1'b1; dataIn = '0; func = '0; crIn = 1'b0;
        leftAddr = '0; rightAddr = '0; destAddr = '0; writeEn = 1'b0; selInput = 1'b0;
        #12;
        check1("reset_crOut", crOut, 1'b0);
        read_reg(4'd5, 32'd0, "reset_r5");
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clock);
            writeEn = vecs[i].we;  selInput = vecs[i].sel; func = vecs[i].fn;
            crIn = vecs[i].ci;     leftAddr = vecs[i].l;   rightAddr = vecs[i].r;
            destAddr = vecs[i].d;  dataIn = vecs[i].din;
            @(posedge clock);
            #1;
            read_reg(vecs[i].chk, vecs[i].exp_d, $sformatf("vec%0d_data", i));
            check1($sformatf("vec%0d_crOut", i), crOut, vecs[i].exp_c);
        end
        read_reg(4'd4, 32'd17, "after_table_r4");

        // No write bypass: old value visible until the writing edge.
        @(negedge clock);
        writeEn = 1'b1; selInput = 1'b0; destAddr = 4'd4; dataIn = 32'h12345678;
        read_reg(4'd4, 32'd17, "no_bypass_before_edge");
        @(posedge clock);
        #1;
        read_reg(4'd4, 32'h12345678, "no_bypass_after_edge");

        // Set crOut to 1, then assert reset between edges.
        @(negedge clock);
        writeEn = 1'b1; selInput = 1'b1; func = 3'd0; leftAddr = 4'd10; rightAddr = 4'd11; destAddr = 4'd12;
        @(posedge clock);
        #1;
        check1("pre_reset_crOut", crOut, 1'b1);
        @(negedge clock);
        writeEn = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check1("async_reset_crOut", crOut, 1'b0);
        read_reg(4'd4, 32'd0, "async_reset_r4");
        read_reg(4'd10, 32'd0, "async_reset_r10");
        @(negedge clock);
        writeEn = 1'b1; selInput = 1'b0; destAddr = 4'd3; dataIn = 32'h00000055;
        @(posedge clock);
        #1;
        read_reg(4'd3, 32'd0, "write_during_reset");
        @(negedge clock);
        writeEn = 1'b0;
        reset = 1'b0;
        for (int r = 0; r < 16; r++) begin
            read_reg(r[3:0], 32'd0, $sformatf("post_reset_r%0d", r));
        end
        check1("post_reset_crOut", crOut, 1'b0);

        // Idle edges with toggling data/func must not change state.
        @(negedge clock);
        writeEn = 1'b1; selInput = 1'b0; destAddr = 4'd2; dataIn = 32'hA5A5A5A5;
        @(posedge clock);
        #1;
        read_reg(4'd2, 32'hA5A5A5A5, "idle_load_r2");
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            writeEn = 1'b0; selInput = k[0]; func = k[2:0] + 3'd1; crIn = ~k[0];
            dataIn = $urandom; leftAddr = 4'd2; rightAddr = 4'd2; destAddr = 4'd2;
            @(posedge clock);
            #1;
            read_reg(4'd2, 32'hA5A5A5A5, $sformatf("idle%0d_r2", k));
            check1($sformatf("idle%0d_crOut", k), crOut, 1'b0);
        end
        read_reg(4'd5, 32'd0, "idle_r5");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
